// File: rtl/rs_branch.sv
// Branch reservation station: buffers branches until both operands arrive, then issues one per cycle.
// Optional RS_BRANCH_BYPASS_EN lets a fully-ready dispatch go straight to the output registers.
module rs_branch_entry #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_clr,
  input  logic [OP_W-1:0]   i_op,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_off,
  input  logic [DATA_W-1:0] i_s1,
  input  logic [DATA_W-1:0] i_s2,
  input  logic              i_v1,
  input  logic              i_v2,
  input  logic [TAG_W-1:0]  i_t1,
  input  logic [TAG_W-1:0]  i_t2,
  input  logic              i_alu_v,
  input  logic [TAG_W-1:0]  i_alu_tag,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_lsu_v,
  input  logic [TAG_W-1:0]  i_lsu_tag,
  input  logic [DATA_W-1:0] i_lsu_data,
  output logic              o_busy,
  output logic              o_ready,
  output logic [OP_W-1:0]   o_op,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_off,
  output logic [DATA_W-1:0] o_s1,
  output logic [DATA_W-1:0] o_s2
);
  logic              r_busy, r_v1, r_v2;
  logic [TAG_W-1:0]  r_t1, r_t2;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_off, r_s1, r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0;
      r_t1 <= '0; r_t2 <= '0; r_op <= '0; r_pc <= '0;
      r_off <= '0; r_s1 <= '0; r_s2 <= '0;
    end else if (i_wr) begin
      r_busy <= 1'b1; r_op <= i_op; r_pc <= i_pc; r_off <= i_off;
      r_v1 <= i_v1; r_s1 <= i_s1; r_t1 <= i_t1;
      r_v2 <= i_v2; r_s2 <= i_s2; r_t2 <= i_t2;
    end else begin
      if (i_clr) r_busy <= 1'b0;
      // ALU bus checked first so it wins a same-tag collision
      if (r_busy && !r_v1) begin
        if (i_alu_v && i_alu_tag == r_t1)      begin r_v1 <= 1'b1; r_s1 <= i_alu_data; end
        else if (i_lsu_v && i_lsu_tag == r_t1) begin r_v1 <= 1'b1; r_s1 <= i_lsu_data; end
      end
      if (r_busy && !r_v2) begin
        if (i_alu_v && i_alu_tag == r_t2)      begin r_v2 <= 1'b1; r_s2 <= i_alu_data; end
        else if (i_lsu_v && i_lsu_tag == r_t2) begin r_v2 <= 1'b1; r_s2 <= i_lsu_data; end
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_ready = r_busy & r_v1 & r_v2;
  assign o_op    = r_op;
  assign o_pc    = r_pc;
  assign o_off   = r_off;
  assign o_s1    = r_s1;
  assign o_s2    = r_s2;
endmodule

module rs_branch #(
  parameter int RS_DEPTH = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 6,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [ADDR_W-1:0] disp_pc,
  input  logic [DATA_W-1:0] disp_offset,
  input  logic [DATA_W-1:0] disp_src1,
  input  logic [DATA_W-1:0] disp_src2,
  input  logic              disp_src1_valid,
  input  logic              disp_src2_valid,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [TAG_W-1:0]  disp_tag2,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              lsu_cdb_valid,
  input  logic [TAG_W-1:0]  lsu_cdb_tag,
  input  logic [DATA_W-1:0] lsu_cdb_data,
  output logic              rs_full,
  output logic              ex_branch_en,
  output logic [DATA_W-1:0] exsrc1,
  output logic [DATA_W-1:0] exsrc2,
  output logic [ADDR_W-1:0] expc,
  output logic [OP_W-1:0]   exaluop,
  output logic [DATA_W-1:0] exoffset
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]             w_busy, w_ready;
  logic [RS_DEPTH-1:0][OP_W-1:0]   w_e_op;
  logic [RS_DEPTH-1:0][ADDR_W-1:0] w_e_pc;
  logic [RS_DEPTH-1:0][DATA_W-1:0] w_e_off, w_e_s1, w_e_s2;
  logic [IDX_W-1:0]                w_sel, w_free;
  logic                            w_any_rdy, w_disp, w_byp;
  logic                            w_d_v1, w_d_v2;
  logic [DATA_W-1:0]               w_d_s1, w_d_s2;

  assign rs_full = &w_busy;
  assign w_disp  = disp_en & ~rs_full;

  always_comb begin
    w_sel = '0; w_any_rdy = 1'b0; w_free = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (w_ready[i]) begin w_sel = IDX_W'(i); w_any_rdy = 1'b1; end
      if (!w_busy[i]) w_free = IDX_W'(i);
    end
  end

  // Same-cycle CDB forwarding into the dispatched op
  always_comb begin
    w_d_v1 = disp_src1_valid; w_d_s1 = disp_src1;
    w_d_v2 = disp_src2_valid; w_d_s2 = disp_src2;
    if (!disp_src1_valid) begin
      if (alu_cdb_valid && alu_cdb_tag == disp_tag1)      begin w_d_v1 = 1'b1; w_d_s1 = alu_cdb_data; end
      else if (lsu_cdb_valid && lsu_cdb_tag == disp_tag1) begin w_d_v1 = 1'b1; w_d_s1 = lsu_cdb_data; end
    end
    if (!disp_src2_valid) begin
      if (alu_cdb_valid && alu_cdb_tag == disp_tag2)      begin w_d_v2 = 1'b1; w_d_s2 = alu_cdb_data; end
      else if (lsu_cdb_valid && lsu_cdb_tag == disp_tag2) begin w_d_v2 = 1'b1; w_d_s2 = lsu_cdb_data; end
    end
  end

`ifdef RS_BRANCH_BYPASS_EN
  assign w_byp = w_disp & w_d_v1 & w_d_v2 & ~w_any_rdy;
`else
  assign w_byp = 1'b0;
`endif

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ent
    rs_branch_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .TAG_W(TAG_W)) u_ent (
      .clk(clk), .rst_n(rst_n),
      .i_wr(w_disp & ~w_byp & (w_free == IDX_W'(i))),
      .i_clr(w_any_rdy & (w_sel == IDX_W'(i))),
      .i_op(disp_op), .i_pc(disp_pc), .i_off(disp_offset),
      .i_s1(w_d_s1), .i_s2(w_d_s2), .i_v1(w_d_v1), .i_v2(w_d_v2),
      .i_t1(disp_tag1), .i_t2(disp_tag2),
      .i_alu_v(alu_cdb_valid), .i_alu_tag(alu_cdb_tag), .i_alu_data(alu_cdb_data),
      .i_lsu_v(lsu_cdb_valid), .i_lsu_tag(lsu_cdb_tag), .i_lsu_data(lsu_cdb_data),
      .o_busy(w_busy[i]), .o_ready(w_ready[i]), .o_op(w_e_op[i]), .o_pc(w_e_pc[i]),
      .o_off(w_e_off[i]), .o_s1(w_e_s1[i]), .o_s2(w_e_s2[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_branch_en <= 1'b0; exsrc1 <= '0; exsrc2 <= '0;
      expc <= '0; exaluop <= '0; exoffset <= '0;
    end else if (w_any_rdy) begin
      ex_branch_en <= 1'b1; exsrc1 <= w_e_s1[w_sel]; exsrc2 <= w_e_s2[w_sel];
      expc <= w_e_pc[w_sel]; exaluop <= w_e_op[w_sel]; exoffset <= w_e_off[w_sel];
    end else if (w_byp) begin
      ex_branch_en <= 1'b1; exsrc1 <= w_d_s1; exsrc2 <= w_d_s2;
      expc <= disp_pc; exaluop <= disp_op; exoffset <= disp_offset;
    end else begin
      ex_branch_en <= 1'b0; exsrc1 <= '0; exsrc2 <= '0;
      expc <= '0; exaluop <= '0; exoffset <= '0;
    end
  end
endmodule

// File: tb/tb_rs_branch.sv
// Bench for rs_branch: directed scenarios plus randomized traffic against a queue-level model.
module tb_rs_branch;
  localparam int D = 4;
  localparam logic [5:0] BEQ = 6'd0, BNE = 6'd1, BLT = 6'd4;
`ifdef RS_BRANCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        disp_en, disp_src1_valid, disp_src2_valid, alu_cdb_valid, lsu_cdb_valid;
  logic [5:0]  disp_op;
  logic [31:0] disp_pc, disp_offset, disp_src1, disp_src2, alu_cdb_data, lsu_cdb_data;
  logic [3:0]  disp_tag1, disp_tag2, alu_cdb_tag, lsu_cdb_tag;
  logic        rs_full, ex_branch_en;
  logic [31:0] exsrc1, exsrc2, expc, exoffset;
  logic [5:0]  exaluop;

  int checks = 0, failures = 0;

  rs_branch dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .disp_op(disp_op), .disp_pc(disp_pc),
    .disp_offset(disp_offset), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_src1_valid(disp_src1_valid), .disp_src2_valid(disp_src2_valid),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsu_cdb_valid(lsu_cdb_valid), .lsu_cdb_tag(lsu_cdb_tag), .lsu_cdb_data(lsu_cdb_data),
    .rs_full(rs_full), .ex_branch_en(ex_branch_en), .exsrc1(exsrc1), .exsrc2(exsrc2),
    .expc(expc), .exaluop(exaluop), .exoffset(exoffset)
  );

  // Reference model: a bag of waiting branches plus the expected output word
  bit          mb[D], mv1[D], mv2[D];
  logic [5:0]  mop[D];
  logic [31:0] mpc[D], moff[D], ms1[D], ms2[D];
  logic [3:0]  mt1[D], mt2[D];
  bit          e_en;
  logic [133:0] e_word;

  function automatic bit model_full();
    for (int i = 0; i < D; i++) if (!mb[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin mb[i] = 0; mv1[i] = 0; mv2[i] = 0; end
    e_en = 0; e_word = '0;
  endtask

  task automatic snoop(input bit v, input logic [3:0] t, input logic [31:0] d,
                       inout bit ov, inout logic [31:0] od);
    if (!ov) begin
      if (alu_cdb_valid && alu_cdb_tag == t) begin ov = 1; od = alu_cdb_data; end
      else if (lsu_cdb_valid && lsu_cdb_tag == t) begin ov = 1; od = lsu_cdb_data; end
    end
  endtask

  task automatic model_step();
    int iss = -1, fr = -1;
    bit full = model_full(), acc, byp = 0, d1v = disp_src1_valid, d2v = disp_src2_valid;
    logic [31:0] d1 = disp_src1, d2 = disp_src2;
    for (int i = 0; i < D; i++) begin
      if (iss < 0 && mb[i] && mv1[i] && mv2[i]) iss = i;
      if (fr < 0 && !mb[i]) fr = i;
    end
    snoop(1, disp_tag1, 0, d1v, d1);
    snoop(1, disp_tag2, 0, d2v, d2);
    acc = disp_en && !full;
`ifdef RS_BRANCH_BYPASS_EN
    byp = acc && d1v && d2v && iss < 0;
`endif
    if (iss >= 0) begin
      e_en = 1; e_word = {ms1[iss], ms2[iss], mpc[iss], mop[iss], moff[iss]}; mb[iss] = 0;
    end else if (byp) begin
      e_en = 1; e_word = {d1, d2, disp_pc, disp_op, disp_offset};
    end else begin
      e_en = 0; e_word = '0;
    end
    for (int i = 0; i < D; i++) if (mb[i]) begin
      snoop(1, mt1[i], 0, mv1[i], ms1[i]);
      snoop(1, mt2[i], 0, mv2[i], ms2[i]);
    end
    if (acc && !byp) begin
      mb[fr] = 1; mop[fr] = disp_op; mpc[fr] = disp_pc; moff[fr] = disp_offset;
      mv1[fr] = d1v; ms1[fr] = d1; mt1[fr] = disp_tag1;
      mv2[fr] = d2v; ms2[fr] = d2; mt2[fr] = disp_tag2;
    end
  endtask

  task automatic tick();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    disp_en = 0; disp_op = 0; disp_pc = 0; disp_offset = 0; disp_src1 = 0; disp_src2 = 0;
    disp_src1_valid = 0; disp_src2_valid = 0; disp_tag1 = 0; disp_tag2 = 0;
    alu_cdb_valid = 0; alu_cdb_tag = 0; alu_cdb_data = 0;
    lsu_cdb_valid = 0; lsu_cdb_tag = 0; lsu_cdb_data = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] off,
                      input logic [31:0] s1, input bit v1, input logic [3:0] t1,
                      input logic [31:0] s2, input bit v2, input logic [3:0] t2);
    disp_en = 1; disp_op = op; disp_pc = pc; disp_offset = off;
    disp_src1 = s1; disp_src1_valid = v1; disp_tag1 = t1;
    disp_src2 = s2; disp_src2_valid = v2; disp_tag2 = t2;
  endtask

  task automatic test_reset();
    idle(); model_reset();
    @(posedge clk); #1;
    checks++;
    if ({rs_full, ex_branch_en, exsrc1, exsrc2, expc, exaluop, exoffset} !== '0) begin
      failures++; $display("FAIL reset_init: got full=%0b en=%0b expected all zero", rs_full, ex_branch_en);
    end
    rst_n = 1;
    for (int i = 0; i < D; i++) begin disp(BEQ, 32'h300 + i, 0, 0, 0, 4'd5, 1, 1, 0); tick(); end
    idle(); alu_cdb_valid = 1; alu_cdb_tag = 4'd5; alu_cdb_data = 32'h55; tick();
    idle(); tick(); tick();
    checks++;
    if (ex_branch_en !== 1'b1 || rs_full !== 1'b0) begin
      failures++; $display("FAIL reset_traffic: got en=%0b full=%0b expected en=1 full=0", ex_branch_en, rs_full);
    end
    #2 rst_n = 0; #1;
    checks++;
    if ({rs_full, ex_branch_en, exsrc1, exsrc2, expc, exaluop, exoffset} !== '0) begin
      failures++; $display("FAIL reset_async: got full=%0b en=%0b pc=%h expected all zero", rs_full, ex_branch_en, expc);
    end
    model_reset(); tick(); tick();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ex_branch_en !== 1'b0 || rs_full !== 1'b0) begin
        failures++; $display("FAIL reset_after: cycle %0d got en=%0b full=%0b expected 0 0", c, ex_branch_en, rs_full);
      end
      tick();
    end
  endtask

  task automatic test_ready();
    disp(BEQ, 32'h100, 32'h20, 5, 1, 0, 5, 1, 0); tick(); idle();
    for (int c = 1; c < LAT; c++) begin
      checks++;
      if (ex_branch_en !== 1'b0) begin failures++; $display("FAIL ready_early: got en=%0b expected 0", ex_branch_en); end
      tick();
    end
    checks++;
    if (ex_branch_en !== 1'b1 || {exaluop, expc, exoffset, exsrc1, exsrc2} !== {BEQ, 32'h100, 32'h20, 32'd5, 32'd5}) begin
      failures++; $display("FAIL ready_issue: got en=%0b op=%h pc=%h off=%h s1=%h s2=%h expected 1 00 100 20 5 5",
                           ex_branch_en, exaluop, expc, exoffset, exsrc1, exsrc2);
    end
    tick();
    checks++;
    if (ex_branch_en !== 1'b0 || expc !== 32'h0) begin
      failures++; $display("FAIL ready_once: got en=%0b pc=%h expected 0 0", ex_branch_en, expc);
    end
  endtask

  task automatic test_wakeup();
    disp(BLT, 32'h140, 32'h8, 0, 0, 4'd3, 7, 1, 0); tick(); idle();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ex_branch_en !== 1'b0) begin failures++; $display("FAIL wake_wait: cycle %0d got en=%0b expected 0", c, ex_branch_en); end
      tick();
    end
    alu_cdb_valid = 1; alu_cdb_tag = 4'd3; alu_cdb_data = 32'hFFFF_FFFF; tick(); idle();
    checks++;
    if (ex_branch_en !== 1'b0) begin failures++; $display("FAIL wake_k1: got en=%0b expected 0", ex_branch_en); end
    tick();
    checks++;
    if (ex_branch_en !== 1'b1 || {exaluop, expc, exsrc1, exsrc2} !== {BLT, 32'h140, 32'hFFFF_FFFF, 32'd7}) begin
      failures++; $display("FAIL wake_issue: got en=%0b op=%h pc=%h s1=%h s2=%h expected 1 04 140 ffffffff 7",
                           ex_branch_en, exaluop, expc, exsrc1, exsrc2);
    end
    tick();
  endtask

  task automatic test_fwd();
    disp(BNE, 32'h180, 32'h4, 3, 1, 0, 0, 0, 4'd9);
    lsu_cdb_valid = 1; lsu_cdb_tag = 4'd9; lsu_cdb_data = 32'h42;
    tick(); idle();
    for (int c = 1; c < LAT; c++) tick();
    checks++;
    if (ex_branch_en !== 1'b1 || {exaluop, exsrc1, exsrc2} !== {BNE, 32'd3, 32'h42}) begin
      failures++; $display("FAIL fwd_issue: got en=%0b op=%h s1=%h s2=%h expected 1 01 3 42",
                           ex_branch_en, exaluop, exsrc1, exsrc2);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) begin disp(BEQ, 32'h200 + 4*i, i, 0, 0, 4'd1, i, 1, 0); tick(); end
    checks++;
    if (rs_full !== 1'b1) begin failures++; $display("FAIL full_set: got %0b expected 1", rs_full); end
    disp(BNE, 32'h999, 0, 1, 1, 0, 1, 1, 0); tick(); idle();
    checks++;
    if (rs_full !== 1'b1 || ex_branch_en !== 1'b0) begin
      failures++; $display("FAIL full_ignore: got full=%0b en=%0b expected 1 0", rs_full, ex_branch_en);
    end
    alu_cdb_valid = 1; alu_cdb_tag = 4'd1; alu_cdb_data = 32'hAB; tick(); idle(); tick();
    for (int i = 0; i < D; i++) begin
      checks++;
      if (ex_branch_en !== 1'b1 || expc !== 32'h200 + 4*i || exsrc1 !== 32'hAB) begin
        failures++; $display("FAIL full_order%0d: got en=%0b pc=%h s1=%h expected 1 %h ab", i, ex_branch_en, expc, exsrc1, 32'h200 + 4*i);
      end
      if (i == 0) begin
        checks++;
        if (rs_full !== 1'b0) begin failures++; $display("FAIL full_drop: got %0b expected 0", rs_full); end
      end
      tick();
    end
    checks++;
    if (ex_branch_en !== 1'b0) begin failures++; $display("FAIL full_extra: got en=%0b pc=%h expected 0", ex_branch_en, expc); end
  endtask

  task automatic test_priority();
    disp(BEQ, 32'h400, 0, 0, 0, 4'd2, 1, 1, 0); tick(); idle();
    alu_cdb_valid = 1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'h11;
    lsu_cdb_valid = 1; lsu_cdb_tag = 4'd2; lsu_cdb_data = 32'h22;
    tick(); idle(); tick();
    checks++;
    if (ex_branch_en !== 1'b1 || exsrc1 !== 32'h11) begin
      failures++; $display("FAIL priority: got en=%0b s1=%h expected 1 11", ex_branch_en, exsrc1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        disp(6'($urandom_range(0, 5)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin alu_cdb_valid = 1; alu_cdb_tag = 4'($urandom_range(0, 7)); alu_cdb_data = $urandom; end
      if ($urandom_range(0, 2) == 0) begin lsu_cdb_valid = 1; lsu_cdb_tag = 4'($urandom_range(0, 7)); lsu_cdb_data = $urandom; end
      tick();
      checks++;
      if (ex_branch_en !== e_en || {exsrc1, exsrc2, expc, exaluop, exoffset} !== e_word || rs_full !== model_full()) begin
        failures++; $display("FAIL random cycle %0d: got en=%0b full=%0b word=%h expected en=%0b full=%0b word=%h",
                             c, ex_branch_en, rs_full, {exsrc1, exsrc2, expc, exaluop, exoffset}, e_en, model_full(), e_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_wakeup();
    test_fwd();
    test_full();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
